muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: nrst  input  1  reset; asynchronous, active-high (1 = reset).
REQ-003 SHALL have port: start  input  1  request pulse; launches an operation when sampled in IDLE.
REQ-004 SHALL have port: op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have port: opa / opb  input  32 each  rs1 / rs2 operand values.
REQ-006 SHALL have port: rd_in  input  5  destination register tag.
REQ-007 SHALL have port: kill  input  1  pipeline flush; aborts any operation in flight.
REQ-008 SHALL have port: busy  output  1  stall request to issue/execute pipe registers.
REQ-009 SHALL have port: done  output  1  single-cycle result-valid pulse.
REQ-010 SHALL have port: result  output  32  final value, meaningful only while done=1.
REQ-011 SHALL have port: rd_out  output  5  tag captured at launch; meaningful while done=1.

Function
REQ-012 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-013 IDLE: start=1 and kill=0 -> PREP; operands, op and rd_in captured on the same edge.
REQ-014 PREP: form absolute values for signed operands, record result sign, clear accumulator, set 5-bit counter to 0; -> CALC.
REQ-015 CALC: one iteration per cycle; multiply = shift-add over a 64-bit product; divide = restoring, one quotient bit per cycle; exactly 32 cycles (counter 0..31); -> FIX after count 31.
REQ-016 FIX: apply sign correction (two's complement negate when required) and select the result half/part; -> DONE.
REQ-017 DONE: done=1 for exactly one cycle; -> IDLE unconditionally.
REQ-018 Normal latency: start sampled at edge E0; done high in the cycle following edge E34; back in IDLE after E35.
REQ-019 busy SHALL be 1 in PREP, CALC and FIX, and 0 in IDLE and DONE.
REQ-020 start sampled outside IDLE SHALL be ignored; it is neither queued nor latched.
REQ-021 MUL -> low 32 bits; MULH/MULHSU/MULHU -> high 32 bits of signed x signed / signed x unsigned / unsigned x unsigned 64-bit product.
REQ-022 Quotient SHALL truncate toward zero; remainder SHALL take the dividend's sign.
REQ-023 Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> opa unchanged.
REQ-024 Signed overflow (opa=0x80000000, opb=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
REQ-025 kill=1 in any state SHALL force IDLE at the next edge with no done pulse; done = (state==DONE) AND NOT kill.
REQ-026 kill and start asserted together in IDLE: kill wins; start is dropped.
REQ-027 result and rd_out SHALL hold their last values outside DONE; no other output depends on them.

Reset
REQ-028 nrst=1 SHALL force IDLE immediately, asynchronously, including mid-operation.
REQ-029 During and after reset: busy=0, done=0, result=0, rd_out=0, counter=0, internal registers=0.
REQ-030 The first start SHALL be accepted on the first rising edge after nrst deasserts.

Configuration
REQ-031 Macro MULDIV_BYPASS_EN, when defined, SHALL let PREP detect divide-by-zero, signed overflow, or a zero multiply operand and go directly to DONE; done is then high in the cycle following E1, with results per REQ-021..024.
REQ-032 With MULDIV_BYPASS_EN undefined, every operation SHALL take the full REQ-018 latency while still producing REQ-023/024 results.

Verification
REQ-033 MUL opa=7, opb=6, rd_in=5 -> busy high 34 cycles; done in the cycle after E34; result=42, rd_out=5.
REQ-034 MULH opa=0xFFFFFFFF, opb=0xFFFFFFFF -> result=0x00000000; MULHU with the same operands -> 0xFFFFFFFE.
REQ-035 DIV opa=-7, opb=2 -> result=0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
REQ-036 DIVU opa=100, opb=0 -> result=0xFFFFFFFF; done after E1 if MULDIV_BYPASS_EN is defined, else after E34.
REQ-037 Start DIV, assert kill at CALC count 10 -> IDLE next edge, no done; a new MUL 3x3 started next cycle -> result=9.
REQ-038 Assert nrst at CALC count 20 -> busy=0 and done=0 immediately; after release, DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential 32-bit RISC-V M-extension multiply/divide unit (shift-add / restoring, 32 iterations).
// Define MULDIV_BYPASS_EN to let trivial cases (x/0, signed overflow, zero multiply operand) finish from PREP.
module muldiv_seq (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [4:0]  rd_in,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_tag;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_den;
  logic        r_neg;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;
  logic [4:0]  r_rdOut;

  logic        w_isDiv;
  logic        w_negA;
  logic        w_negB;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic        w_negRes;
  logic        w_divZero;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [63:0] w_prod;
  logic [63:0] w_prodFix;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_fixRes;

  assign w_isDiv   = r_op[2];
  assign w_negA    = r_a[31] & ((r_op == OP_MULH) | (r_op == OP_MULHSU) | (r_op == OP_DIV) | (r_op == OP_REM));
  assign w_negB    = r_b[31] & ((r_op == OP_MULH) | (r_op == OP_DIV) | (r_op == OP_REM));
  assign w_absA    = w_negA ? -r_a : r_a;
  assign w_absB    = w_negB ? -r_b : r_b;
  // Remainder follows the dividend only; every other result follows the product/quotient sign.
  assign w_negRes  = (r_op[2] & r_op[1]) ? w_negA : (w_negA ^ w_negB);
  assign w_divZero = w_isDiv & (r_b == 32'd0);

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_den} : 33'd0);
  assign w_shift = {r_hi, r_lo[31]};
  assign w_diff  = w_shift - {1'b0, r_den};
  assign w_fits  = ~w_diff[32];

  assign w_prod    = {r_hi, r_lo};
  assign w_prodFix = r_neg ? -w_prod : w_prod;
  assign w_quo     = r_neg ? -r_lo : r_lo;
  assign w_rem     = r_neg ? -r_hi : r_hi;

  always_comb begin
    w_fixRes = 32'd0;
    case (r_op)
      OP_MUL:           w_fixRes = w_prodFix[31:0];
      3'd1, 3'd2, 3'd3: w_fixRes = w_prodFix[63:32];
      3'd4, 3'd5:       w_fixRes = w_divZero ? 32'hFFFF_FFFF : w_quo;
      default:          w_fixRes = w_rem;
    endcase
  end

`ifdef MULDIV_BYPASS_EN
  logic        w_ovf;
  logic        w_mulZero;
  logic [31:0] w_bypassRes;

  assign w_ovf       = ((r_op == OP_DIV) | (r_op == OP_REM)) & (r_a == 32'h8000_0000) & (r_b == 32'hFFFF_FFFF);
  assign w_mulZero   = ~w_isDiv & ((r_a == 32'd0) | (r_b == 32'd0));
  assign w_bypassRes = w_divZero ? (r_op[1] ? r_a : 32'hFFFF_FFFF) :
                       w_ovf     ? (r_op[1] ? 32'd0 : 32'h8000_0000) : 32'd0;
`endif

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state  <= IDLE;
      r_op     <= 3'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_tag    <= 5'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_den    <= 32'd0;
      r_neg    <= 1'b0;
      r_cnt    <= 5'd0;
      r_result <= 32'd0;
      r_rdOut  <= 5'd0;
    end else if (kill) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_op    <= op;
          r_a     <= opa;
          r_b     <= opb;
          r_tag   <= rd_in;
          r_state <= PREP;
        end
        PREP: begin
          // Multiply: r_den = multiplicand, r_lo = multiplier. Divide: r_den = divisor, r_lo = dividend.
          r_hi  <= 32'd0;
          r_cnt <= 5'd0;
          r_neg <= w_negRes;
          r_den <= w_isDiv ? w_absB : w_absA;
          r_lo  <= w_isDiv ? w_absA : w_absB;
`ifdef MULDIV_BYPASS_EN
          if (w_divZero | w_ovf | w_mulZero) begin
            r_result <= w_bypassRes;
            r_rdOut  <= r_tag;
            r_state  <= DONE;
          end else begin
            r_state <= CALC;
          end
`else
          r_state <= CALC;
`endif
        end
        CALC: begin
          if (w_isDiv) begin
            r_hi <= w_fits ? w_diff[31:0] : w_shift[31:0];
            r_lo <= {r_lo[30:0], w_fits};
          end else begin
            r_hi <= w_sum[32:1];
            r_lo <= {w_sum[0], r_lo[31:1]};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= FIX;
        end
        FIX: begin
          r_result <= w_fixRes;
          r_rdOut  <= r_tag;
          r_state  <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = (r_state == PREP) | (r_state == CALC) | (r_state == FIX);
  assign done   = (r_state == DONE) & ~kill;
  assign result = r_result;
  assign rd_out = r_rdOut;

endmodule
